// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: raster-order step sequencer for the stochastic-computing
// convolution line buffer. It walks sc position (innermost), column and then row,
// flags full-window steps, and handshakes with the bitstream source and result sink.
module conv_window_sequencer #(
  parameter int INPUT_WIDTH   = 32,
  parameter int INPUT_HEIGHT  = 32,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int SC_LEN        = 256,
  localparam int COL_W = (INPUT_WIDTH  > 1) ? $clog2(INPUT_WIDTH)  : 1,
  localparam int ROW_W = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1,
  localparam int SC_W  = (SC_LEN       > 1) ? $clog2(SC_LEN)       : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             buf_enable,
  output logic [COL_W-1:0] width_index,
  output logic [ROW_W-1:0] row_index,
  output logic [SC_W-1:0]  sc_count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(INPUT_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(INPUT_HEIGHT - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SC_LEN - 1);
  localparam logic [COL_W-1:0] COL_OFF  = COL_W'(KERNEL_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_OFF  = ROW_W'(KERNEL_HEIGHT - 1);

  logic [1:0] state;
  logic       run;
  logic       col_ok;
  logic       window_valid;
  logic       step;
  logic       sc_wrap;
  logic       col_wrap;
  logic       last_step;

  // Handshake and strobe decode from registered state plus in_valid/out_ready
  always_comb begin
    run          = (state == RUN);
    col_ok       = (width_index >= COL_OFF);
    window_valid = (row_index >= ROW_OFF) && col_ok;
    in_ready     = run && (out_ready || !window_valid);
    out_valid    = run && in_valid && window_valid;
    step         = run && in_valid && in_ready;
    buf_enable   = step && col_ok;
    sc_wrap      = (sc_count == SC_LAST);
    col_wrap     = (width_index == COL_LAST);
    last_step    = sc_wrap && col_wrap && (row_index == ROW_LAST);
    out_row      = run ? (row_index - ROW_OFF) : '0;
    out_col      = run ? (width_index - COL_OFF) : '0;
    busy         = run;
    done         = (state == DONE);
  end

  // Frame control: IDLE -> RUN on start, RUN -> DONE on the final step, DONE -> IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (step && last_step) state <= DONE;
        // a start arriving during the done pulse launches the next frame directly
        DONE:    state <= start ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Raster counters: sc innermost, then column, then row; all wrap to 0 on the final step
  always_ff @(posedge clock) begin
    if (reset) begin
      sc_count    <= '0;
      width_index <= '0;
      row_index   <= '0;
    end else if (step) begin
      if (sc_wrap) begin
        sc_count <= '0;
        if (col_wrap) begin
          width_index <= '0;
          row_index   <= (row_index == ROW_LAST) ? '0 : row_index + 1'b1;
        end else begin
          width_index <= width_index + 1'b1;
        end
      end else begin
        sc_count <= sc_count + 1'b1;
      end
    end
  end

endmodule
